// File: rtl/divisor_sequencial_pkg.sv
// Shared definitions for the sequential divider: default operand width and FSM states.
package divisor_sequencial_pkg;

  localparam int TAM_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divisor_sequencial_subtrator.sv
// Combinational W+1 bit subtractor, same form as somador; MSB of the result is the borrow.
module divisor_sequencial_subtrator #(
  parameter int W = 8
) (
  input  logic [W:0] a_i,
  input  logic [W:0] b_i,
  output logic [W:0] dif_o
);

  assign dif_o = a_i - b_i;

endmodule

// File: rtl/divisor_sequencial.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock, start/busy/done handshake.
module divisor_sequencial
  import divisor_sequencial_pkg::*;
#(
  parameter int TAM = TAM_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [TAM-1:0] dividendo,
  input  logic [TAM-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [TAM-1:0] quociente,
  output logic [TAM-1:0] resto,
  output logic           div_zero
);

  localparam int CW = $clog2(TAM + 1);

  state_t         state_q, state_d;
  logic [TAM-1:0] rem_q, rem_d;
  logic [TAM-1:0] qacc_q, qacc_d;
  logic [TAM-1:0] dvsr_q, dvsr_d;
  logic [TAM-1:0] quo_q, quo_d;
  logic [TAM-1:0] resto_q, resto_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;

  logic [TAM:0]   trial;
  logic           borrow;
  logic [TAM-1:0] rem_nx, qacc_nx;

  divisor_sequencial_subtrator #(.W(TAM)) u_sub (
    .a_i   ({rem_q, qacc_q[TAM-1]}),
    .b_i   ({1'b0, dvsr_q}),
    .dif_o (trial)
  );

  // rem_q < divisor always holds, so the trial result fits in TAM bits unless it borrowed
  assign borrow  = trial[TAM];
  assign rem_nx  = borrow ? {rem_q[TAM-2:0], qacc_q[TAM-1]} : trial[TAM-1:0];
  assign qacc_nx = {qacc_q[TAM-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    resto_d = resto_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvsr_d  = divisor;
            rem_d   = '0;
            qacc_d  = dividendo;
            cnt_d   = CW'(TAM);
            state_d = CALC;
          end else begin
            quo_d   = '1;
            resto_d = dividendo;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        rem_d  = rem_nx;
        qacc_d = qacc_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = qacc_nx;
          resto_d = rem_nx;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      qacc_q  <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      resto_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      resto_q <= resto_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign quociente = quo_q;
  assign resto     = resto_q;
  assign div_zero  = dz_q;

endmodule
